// File: rtl/spi_rx_fifo_pkg.sv
// Shared SPI master constants: word width, RX FIFO depth and pointer width,
// used by the receiver, the RX FIFO and the APB register block.
package spi_rx_fifo_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 32;
  localparam int unsigned SPI_FIFO_DEPTH = 8;
  localparam int unsigned SPI_FIFO_PTR_W = $clog2(SPI_FIFO_DEPTH);

  // Per-cycle FIFO operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/spi_rx_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// asynchronous read port. The array is deliberately not reset.
module spi_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO between the SPI receiver and the APB
// read path, with occupancy count and a registered threshold interrupt.
module spi_rx_fifo
  import spi_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned DEPTH      = SPI_FIFO_DEPTH,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      elements_o,
  input  logic [CNT_W-1:0]      thresh_i,
  output logic                  thresh_irq_o
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  irq_q, irq_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_op_e              op;

  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign op      = fifo_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_d    = 1'b0;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        FIFO_PUSH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        FIFO_POP: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
        FIFO_BOTH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
      // Compared against the next count so the flag moves with elements_o.
      irq_d = (count_d >= thresh_i) && (thresh_i != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  spi_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push && !clr_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // The array has no reset, so the head word is masked while empty.
  assign data_o       = valid_o ? rd_data : '0;
  assign elements_o   = count_q;
  assign thresh_irq_o = irq_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Self-checking bench for spi_rx_fifo: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_spi_rx_fifo;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          clr_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] elements_o;
  logic [CW-1:0] thresh_i = '0;
  logic          thresh_irq_o;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] model_q[$];
  logic          model_irq = 1'b0;

  always #5 clk_i = ~clk_i;

  spi_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clr_i        (clr_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .elements_o   (elements_o),
    .thresh_i     (thresh_i),
    .thresh_irq_o (thresh_irq_o)
  );

  typedef struct {
    logic          clr;
    logic          vin;
    logic [DW-1:0] din;
    logic          rin;
    logic [CW-1:0] thr;
    logic [CW-1:0] e_elem;
    logic          e_valid;
    logic          e_ready;
    logic [DW-1:0] e_data;
    logic          e_irq;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_model(input string nm);
    logic [DW-1:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : '0;
    chk({nm, ".elements"}, DW'(elements_o), DW'(model_q.size()));
    chk({nm, ".valid"},    DW'(valid_o),    DW'(model_q.size() > 0));
    chk({nm, ".ready"},    DW'(ready_o),    DW'(model_q.size() < DP));
    chk({nm, ".data"},     data_o,          exp_data);
    chk({nm, ".irq"},      DW'(thresh_irq_o), DW'(model_irq));
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, and
  // sample the DUT 1 ns after the rising edge.
  task automatic cyc(input logic c, input logic v, input logic [DW-1:0] d,
                     input logic r, input logic [CW-1:0] t, input string nm);
    int  sz;
    bit  do_push, do_pop;
    clr_i = c; valid_i = v; data_i = d; ready_i = r; thresh_i = t;
    sz      = model_q.size();
    do_push = v && (sz < DP);
    do_pop  = r && (sz > 0);
    @(posedge clk_i);
    #1;
    if (c) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    model_irq = !c && (t != 0) && (model_q.size() >= int'(t));
    check_model(nm);
    clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, ".elements"}, DW'(elements_o), 0);
    chk({nm, ".valid"},    DW'(valid_o), 0);
    chk({nm, ".ready"},    DW'(ready_o), 1);
    chk({nm, ".irq"},      DW'(thresh_irq_o), 0);
    chk({nm, ".data"},     data_o, 0);
  endtask

  initial begin
    logic [DW-1:0] popped[$];
    int            next_idx;
    int            budget;
    bit            irq_seen;

    vecs[0] = '{1'b0, 1'b1, 32'h11111111, 1'b0, 4'd2, 4'd1, 1'b1, 1'b1, 32'h11111111, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h22222222, 1'b0, 4'd2, 4'd2, 1'b1, 1'b1, 32'h11111111, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h33333333, 1'b0, 4'd2, 4'd3, 1'b1, 1'b1, 32'h11111111, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 32'h22222222, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 32'h33333333, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h44444444, 1'b1, 4'd2, 4'd1, 1'b1, 1'b1, 32'h44444444, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h55555555, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 32'h0,        1'b0};

    // Reset state
    #2;
    check_reset_vals("reset");
    #5 rstn_i = 1'b1;
    @(negedge clk_i);

    // Constant vector table: basic FIFO order, empty push/pop, clear
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].clr, vecs[i].vin, vecs[i].din, vecs[i].rin, vecs[i].thr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_elem", i),  DW'(elements_o), DW'(vecs[i].e_elem));
      chk($sformatf("vec%0d.tbl_valid", i), DW'(valid_o), DW'(vecs[i].e_valid));
      chk($sformatf("vec%0d.tbl_ready", i), DW'(ready_o), DW'(vecs[i].e_ready));
      chk($sformatf("vec%0d.tbl_data", i),  data_o, vecs[i].e_data);
      chk($sformatf("vec%0d.tbl_irq", i),   DW'(thresh_irq_o), DW'(vecs[i].e_irq));
    end

    // Fill to full, blocked push, pop at full, push+pop at DEPTH-1
    for (int i = 0; i < DP; i++) cyc(0, 1, 32'hA0000000 + DW'(i), 0, 0, "fill");
    chk("full.ready", DW'(ready_o), 0);
    chk("full.elements", DW'(elements_o), DP);
    cyc(0, 1, 32'hDEADBEEF, 0, 0, "full_blocked");
    chk("full_blocked.elements", DW'(elements_o), DP);
    chk("full_blocked.head", data_o, 32'hA0000000);
    cyc(0, 1, 32'hCAFE0001, 1, 0, "full_pop");
    chk("full_pop.elements", DW'(elements_o), DP - 1);
    cyc(0, 1, 32'hCAFE0002, 1, 0, "both");
    chk("both.elements", DW'(elements_o), DP - 1);
    while (model_q.size() > 0) cyc(0, 0, 0, 1, 0, "drain");

    // 20 indexed words with occupancy bounded to 5, across two wraps
    popped.delete();
    next_idx = 0;
    budget   = 400;
    while (popped.size() < 20 && budget > 0) begin
      logic v, r;
      v = (next_idx < 20) && (model_q.size() < 5) && ($urandom_range(0, 3) != 0);
      r = (model_q.size() == 5) || ($urandom_range(0, 1) == 1);
      if (r && valid_o) popped.push_back(data_o);
      cyc(0, v, DW'(next_idx), r, 0, "wrap");
      if (v) next_idx++;
      budget--;
    end
    chk("wrap.count", DW'(popped.size()), 20);
    for (int i = 0; i < popped.size(); i++) chk($sformatf("wrap.seq%0d", i), popped[i], DW'(i));

    // Threshold 4: rises with elements_o==4, falls after one pop
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hB0 + DW'(i), 0, 4, "thr_fill");
    chk("thr.below", DW'(thresh_irq_o), 0);
    cyc(0, 1, 32'hB3, 0, 4, "thr_hit");
    chk("thr.at", DW'(thresh_irq_o), 1);
    chk("thr.at_elem", DW'(elements_o), 4);
    cyc(0, 0, 0, 1, 4, "thr_pop");
    chk("thr.after_pop", DW'(thresh_irq_o), 0);
    // Threshold 0 never asserts, even when full
    irq_seen = 0;
    for (int i = 0; i < DP; i++) begin
      cyc(0, 1, 32'hC0 + DW'(i), 0, 0, "thr0");
      if (thresh_irq_o) irq_seen = 1;
    end
    chk("thr0.never", DW'(irq_seen), 0);

    // Clear at 5 with push and pop requested
    cyc(1, 0, 0, 0, 0, "pre_clr");
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'hD0 + DW'(i), 0, 3, "clr_fill");
    chk("clr.pre_irq", DW'(thresh_irq_o), 1);
    cyc(1, 1, 32'h12345678, 1, 3, "clr");
    chk("clr.elements", DW'(elements_o), 0);
    chk("clr.valid", DW'(valid_o), 0);
    chk("clr.irq", DW'(thresh_irq_o), 0);
    chk("clr.ready", DW'(ready_o), 1);

    // Asynchronous reset between edges at occupancy 6
    for (int i = 0; i < 6; i++) cyc(0, 1, 32'hE0 + DW'(i), 0, 2, "arst_fill");
    chk("arst.pre_elem", DW'(elements_o), 6);
    #2 rstn_i = 1'b0;
    #1 check_reset_vals("arst");
    #1 rstn_i = 1'b1;
    model_q.delete();
    model_irq = 1'b0;
    @(negedge clk_i);
    cyc(0, 1, 32'hA5A5A5A5, 0, 0, "arst_push");
    chk("arst.first_word", data_o, 32'hA5A5A5A5);
    cyc(0, 0, 0, 1, 0, "arst_pop");

    // Randomized traffic against the queue model
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 24) == 0), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 1), CW'($urandom_range(0, DP)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
